// File: rtl/mmu_pkg.sv
// Shared defaults and lane-slicing helper for the weight-stationary matrix unit.
// Lane 0 of every packed bus occupies the most-significant slice.
package mmu_pkg;

  localparam int N_DEF      = 4;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;

  // LSB position of lane idx in a bus of 'lanes' slices, each 'width' bits.
  function automatic int lane_lsb(input int idx, input int lanes, input int width);
    return (lanes - 1 - idx) * width;
  endfunction

endpackage

// File: rtl/mmu_pe.sv
// One weight-stationary PE: shifts weights down while loading, MACs while computing.
// One-cycle latency from a_in/p_in to a/p; no backpressure, accepts every cycle.
module mmu_pe
  import mmu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              control,
  input  logic [DATA_W-1:0] wt_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [ACC_W-1:0]  p_in,
  output logic [DATA_W-1:0] w,
  output logic [DATA_W-1:0] a,
  output logic [ACC_W-1:0]  p
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    mac;

  // Unsigned product; the sum wraps modulo 2^ACC_W.
  always_comb begin
    prod = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, w};
    mac  = p_in + ACC_W'(prod);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w <= '0;
      a <= '0;
      p <= '0;
    end else if (control) begin
      w <= wt_in;
      a <= '0;
      p <= '0;
    end else begin
      a <= a_in;
      p <= mac;
    end
  end

endmodule

// File: rtl/mmu.sv
// N x N weight-stationary systolic matrix unit; column j of a skewed vector started
// in cycle k is valid after edge k+N-1+j; no backpressure, one vector per cycle.
module mmu
  import mmu_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                control,
  input  logic [N*DATA_W-1:0] wt_arr,
  input  logic [N*DATA_W-1:0] data_arr,
  output logic [N*ACC_W-1:0]  acc_out
);

  logic [DATA_W-1:0] w_q [N][N];
  logic [DATA_W-1:0] a_q [N][N];
  logic [ACC_W-1:0]  p_q [N][N];

  // Bottom-row weights and last-column activations have no consumer.
  logic [N*DATA_W-1:0] unused_w_tail;
  logic [N*DATA_W-1:0] unused_a_tail;

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      localparam int COL_LSB = lane_lsb(j, N, DATA_W);
      localparam int ROW_LSB = lane_lsb(i, N, DATA_W);

      logic [DATA_W-1:0] wt_in;
      logic [DATA_W-1:0] a_in;
      logic [ACC_W-1:0]  p_in;

      if (i == 0) begin : g_first_row
        assign wt_in = wt_arr[COL_LSB +: DATA_W];
        assign p_in  = '0;
      end else begin : g_inner_row
        assign wt_in = w_q[i-1][j];
        assign p_in  = p_q[i-1][j];
      end

      if (j == 0) begin : g_first_col
        assign a_in = data_arr[ROW_LSB +: DATA_W];
      end else begin : g_inner_col
        assign a_in = a_q[i][j-1];
      end

      mmu_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk     (clk),
        .rst     (rst),
        .control (control),
        .wt_in   (wt_in),
        .a_in    (a_in),
        .p_in    (p_in),
        .w       (w_q[i][j]),
        .a       (a_q[i][j]),
        .p       (p_q[i][j])
      );
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_out
    localparam int ACC_LSB  = lane_lsb(j, N, ACC_W);
    localparam int DATA_LSB = lane_lsb(j, N, DATA_W);
    assign acc_out[ACC_LSB +: ACC_W]        = p_q[N-1][j];
    assign unused_w_tail[DATA_LSB +: DATA_W] = w_q[N-1][j];
    assign unused_a_tail[DATA_LSB +: DATA_W] = a_q[j][N-1];
  end

endmodule

// File: tb/tb_mmu.sv
// Directed bench for mmu: weight load, skewed streams, weight hold, overflow/wrap, resets.
// Runs a 32-bit and a 16-bit accumulator instance side by side on the same stimulus.
module tb_mmu;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int AW   = 32;
  localparam int AW16 = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              control;
  logic [N*DW-1:0]   wt_arr;
  logic [N*DW-1:0]   data_arr;
  logic [N*AW-1:0]   acc_out;
  logic [N*AW16-1:0] acc16;

  always #5 clk = ~clk;

  mmu #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .control  (control),
    .wt_arr   (wt_arr),
    .data_arr (data_arr),
    .acc_out  (acc_out)
  );

  mmu #(.N(N), .DATA_W(DW), .ACC_W(AW16)) dut16 (
    .clk      (clk),
    .rst      (rst),
    .control  (control),
    .wt_arr   (wt_arr),
    .data_arr (data_arr),
    .acc_out  (acc16)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]       stim [$];
  logic [7:0]        w_model [N][N];
  logic [N*AW-1:0]   cap [$];
  logic [N*AW16-1:0] cap16 [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lane32(input logic [N*AW-1:0] bus, input int j);
    return bus[(N-1-j)*AW +: AW];
  endfunction

  function automatic logic [31:0] lane16(input logic [N*AW16-1:0] bus, input int j);
    return {16'h0, bus[(N-1-j)*AW16 +: AW16]};
  endfunction

  // Column j of the vector whose row-0 element enters in cycle k.
  function automatic logic [31:0] model(input int k, input int j);
    logic [31:0] s;
    logic [31:0] wd;
    logic [7:0]  a;
    s = 0;
    for (int i = 0; i < N; i++) begin
      a = 8'h0;
      if ((k + i) >= 0 && (k + i) < stim.size()) begin
        wd = stim[k + i];
        a  = wd[(N-1-i)*DW +: DW];
      end
      s += 32'(a) * 32'(w_model[i][j]);
    end
    return s;
  endfunction

  task automatic check_zero(input string tag);
    for (int j = 0; j < N; j++) begin
      check_val($sformatf("%s c%0d", tag, j), lane32(acc_out, j), 32'h0);
      check_val($sformatf("%s16 c%0d", tag, j), lane16(acc16, j), 32'h0);
    end
  endtask

  task automatic do_reset(input logic ctl, input logic [31:0] wt, input string tag);
    rst      = 1'b1;
    control  = ctl;
    wt_arr   = wt;
    data_arr = 32'h0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        w_model[i][j] = 8'h0;
    check_zero(tag);
  endtask

  task automatic load(input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3, input string tag);
    logic [31:0] words [4];
    words = '{w0, w1, w2, w3};
    for (int n = 0; n < 4; n++) begin
      control  = 1'b1;
      wt_arr   = words[n];
      data_arr = $urandom;
      tick();
      for (int r = N-1; r > 0; r--)
        for (int j = 0; j < N; j++)
          w_model[r][j] = w_model[r-1][j];
      for (int j = 0; j < N; j++)
        w_model[0][j] = words[n][(N-1-j)*DW +: DW];
      check_zero($sformatf("%s e%0d", tag, n));
    end
  endtask

  task automatic run_stream(input int n_edges, input bit rand_wt, input string tag);
    logic [31:0] exp;
    control = 1'b0;
    cap.delete();
    cap16.delete();
    for (int e = 0; e < n_edges; e++) begin
      data_arr = (e < stim.size()) ? stim[e] : 32'h0;
      wt_arr   = rand_wt ? $urandom : 32'h0;
      tick();
      cap.push_back(acc_out);
      cap16.push_back(acc16);
      for (int j = 0; j < N; j++) begin
        exp = model(e - (N-1) - j, j);
        check_val($sformatf("%s e%0d c%0d", tag, e, j), lane32(acc_out, j), exp);
        check_val($sformatf("%s16 e%0d c%0d", tag, e, j), lane16(acc16, j), {16'h0, exp[15:0]});
      end
    end
  endtask

  logic [31:0] hand1 [4];
  logic [31:0] hand2 [4];

  initial begin
    rst      = 1'b0;
    control  = 1'b0;
    wt_arr   = 32'h0;
    data_arr = 32'h0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        w_model[i][j] = 8'h0;

    do_reset(1'b0, 32'h0, "reset");

    load(32'h05020304, 32'h03010203, 32'h07040102, 32'h01020403, "load");

    stim = '{32'h00000000, 32'h01000000, 32'h02020000, 32'h03030500,
             32'h04040606, 32'h00050707, 32'h00000808, 32'h00000009};
    run_stream(16, 1'b0, "stream");

    // Vector (1,2,5,6) from cycle 1 and (2,3,6,7) from cycle 2, computed by hand.
    hand1 = '{32'd60, 32'd27, 32'd34, 32'd46};
    hand2 = '{32'd76, 32'd36, 32'd44, 32'd58};
    for (int j = 0; j < N; j++) begin
      check_val($sformatf("vec1 c%0d", j), lane32(cap[1 + 3 + j], j), hand1[j]);
      check_val($sformatf("vec2 c%0d", j), lane32(cap[2 + 3 + j], j), hand2[j]);
    end

    run_stream(16, 1'b1, "hold");

    run_stream(5, 1'b0, "pre_load");
    load(32'h05020304, 32'h03010203, 32'h07040102, 32'h01020403, "midload");
    run_stream(16, 1'b0, "reload");

    load(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "ffload");
    stim = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    run_stream(16, 1'b0, "ovf");
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < N; j++) begin
        check_val($sformatf("ovf k%0d c%0d", k, j), lane32(cap[k + 3 + j], j), 32'd260100);
        check_val($sformatf("wrap k%0d c%0d", k, j), lane16(cap16[k + 3 + j], j), 32'd63492);
      end

    stim = '{32'h00000000, 32'h01000000, 32'h02020000, 32'h03030500,
             32'h04040606, 32'h00050707, 32'h00000808, 32'h00000009};
    load(32'h05020304, 32'h03010203, 32'h07040102, 32'h01020403, "load3");
    run_stream(5, 1'b0, "pre_rst");
    // Reset asserted together with a load of 0xFF weights: reset must win.
    do_reset(1'b1, 32'hFFFFFFFF, "mid_rst");
    run_stream(16, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmu.md
MMU -- requirements
Module: mmu

Interface
REQ-001 Parameter N, default 4: array dimension (rows = columns = N).
REQ-002 Parameter DATA_W, default 8: operand width for weights and activations.
REQ-003 Parameter ACC_W, default 32: partial-sum and output lane width.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 control  input  1: 1 = weight-load mode; 0 = compute mode.
REQ-007 wt_arr  input  N*DATA_W: one weight row; byte [31:24] = column 0 ... byte [7:0] = column 3.
REQ-008 data_arr  input  N*DATA_W: skewed activations; byte [31:24] = row 0 ... byte [7:0] = row 3.
REQ-009 acc_out  output  N*ACC_W: column results; [127:96] = column 0 ... [31:0] = column 3.

Function
REQ-010 The array SHALL be N x N weight-stationary processing elements (PEs); each PE(i,j) holds w (DATA_W), a (DATA_W) and p (ACC_W) registers.
REQ-011 When control=1, each edge SHALL shift weights down one row: row 0 w <= wt_arr column byte; row i w <= row i-1 w.
REQ-012 After N load edges, the first-loaded word SHALL reside in row N-1 and the last-loaded word in row 0.
REQ-013 When control=1, all a and p registers SHALL be cleared to 0, so acc_out reads 0 from the edge after control rises.
REQ-014 When control=0, weights SHALL hold unchanged indefinitely.
REQ-015 When control=0, PE(i,j) SHALL register a <= a_in and p <= p_in + a_in*w.
REQ-016 a_in of PE(i,0) SHALL be data_arr row-i byte (combinational); a_in of PE(i,j>0) SHALL be a of PE(i,j-1).
REQ-017 p_in of PE(0,j) SHALL be 0; p_in of PE(i>0,j) SHALL be p of PE(i-1,j).
REQ-018 Multiplication SHALL be unsigned DATA_W x DATA_W; accumulation SHALL be unsigned modulo 2^ACC_W (wrap, no saturation).
REQ-019 acc_out column j SHALL be p of PE(N-1,j), driven directly from registers.
REQ-020 The driver SHALL apply vector element a_i in cycle k+i (row skew of one cycle per row).
REQ-021 Column j of that vector SHALL equal sum over i of a_i*w(i,j) and SHALL appear on acc_out after edge k+N-1+j.
REQ-022 Back-to-back vectors SHALL be accepted every cycle with no bubbles; zero bytes contribute 0.
REQ-023 Raising control mid-stream SHALL discard all in-flight partial sums at the next edge.

Reset
REQ-024 When rst=1 at an edge, all w, a and p registers SHALL clear to 0, so acc_out = 0 after that edge.
REQ-025 rst SHALL take priority over control.
REQ-026 No register SHALL be reset asynchronously.

Structure
REQ-027 Package mmu_pkg SHALL hold N, DATA_W and ACC_W defaults and the byte/lane slicing helper constants.
REQ-028 One sub-module mmu_pe (single PE with load/compute behaviour) SHALL be instantiated N*N times via generate.

Verification
REQ-029 Load test: rst; then control=1 with wt_arr 05020304, 03010203, 07040102, 01020403 over 4 edges -> row 0 weights (1,2,4,3), row 3 weights (5,2,3,4); acc_out=0.
REQ-030 Skewed stream test: after the load, control=0 with data_arr 00000000, 01000000, 02020000, 03030500, 04040606, 00050707, 00000808, 00000009.
REQ-031 Expected result for REQ-030: vector (1,2,5,6) yields column 0..3 = 60, 27, 34, 46, each at its REQ-021 cycle; later vectors match a software golden model.
REQ-032 Weight hold: weights loaded, control=0, wt_arr toggled randomly -> results unchanged.
REQ-033 Overflow: all weights and activations 0xFF over repeated streams -> each column = 4*65025 = 260100 per vector; wrap is checked with ACC_W overridden to 16.
REQ-034 Reset mid-stream: rst=1 during compute -> acc_out=0 and weights 0 after that edge; a subsequent stream yields all-zero columns until weights are reloaded.
